// File: rtl/wwdt_apb.sv
// Window watchdog with APB register port, prescaled down-counter and refresh window.
// Optional early-warning interrupt (EWI/EWIF) is built only when WWDT_EWI_EN is defined.
module wwdt_apb #(
    parameter int unsigned CNT_W    = 7,
    parameter int unsigned PSC_LOG2 = 12
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic [3:0]  paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        wdt_rst,
    output logic        wdt_intr
);
    // Wide enough for the largest prescaler period, 2^(PSC_LOG2+3).
    localparam int unsigned PSC_W = PSC_LOG2 + 3;
    localparam logic [CNT_W-1:0] T_HALF = {1'b1, {(CNT_W-1){1'b0}}};

    logic [CNT_W-1:0] t_q, t_d;
    logic [CNT_W-1:0] w_q, w_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [1:0]       wdgtb_q, wdgtb_d;
    logic             wdga_q, wdga_d;
    logic             rstf_q, rstf_d;
    logic             wdt_rst_q, wdt_rst_d;
    logic             ewi_q, ewif_q;

    logic             cr_sel, cfr_sel, sr_sel, wr_en;
    logic             cr_wr, cfr_wr, sr_wr;
    logic [PSC_W-1:0] psc_max;
    logic             tick_raw, tick, trip;
    logic [31:0]      cr_rd, cfr_rd, sr_rd;
    logic             unused_pwdata;

    assign unused_pwdata = ^pwdata;

    always_comb begin
        cr_sel   = (paddr == 4'h0);
        cfr_sel  = (paddr == 4'h4);
        sr_sel   = (paddr == 4'h8);
        wr_en    = psel & penable & pwrite;
        cr_wr    = wr_en & cr_sel;
        cfr_wr   = wr_en & cfr_sel;
        sr_wr    = wr_en & sr_sel;
        psc_max  = (PSC_W'(1) << (PSC_LOG2 + 32'(wdgtb_q))) - PSC_W'(1);
        tick_raw = wdga_q && (psc_q == psc_max);
        // A CR write in the same cycle swallows the tick.
        tick     = tick_raw && !cr_wr;
        trip     = (tick && (t_q == T_HALF))
                 | (cr_wr && wdga_q && (t_q > w_q))
                 | (cr_wr && (wdga_q || pwdata[31]) && !pwdata[CNT_W-1]);
    end

`ifdef WWDT_EWI_EN
    logic ewi_d, ewif_d;

    always_comb begin
        ewi_d  = ewi_q;
        ewif_d = ewif_q;
        if (sr_wr && pwdata[0]) ewif_d = 1'b0;
        if (tick && (t_q == T_HALF + CNT_W'(1))) ewif_d = 1'b1;
        if (cfr_wr) ewi_d = pwdata[24];
        if (trip) begin
            ewi_d  = 1'b0;
            ewif_d = 1'b0;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ewi_q  <= 1'b0;
            ewif_q <= 1'b0;
        end else begin
            ewi_q  <= ewi_d;
            ewif_q <= ewif_d;
        end
    end
`else
    assign ewi_q  = 1'b0;
    assign ewif_q = 1'b0;
`endif

    always_comb begin
        t_d       = t_q;
        w_d       = w_q;
        psc_d     = psc_q;
        wdgtb_d   = wdgtb_q;
        wdga_d    = wdga_q;
        rstf_d    = rstf_q;
        wdt_rst_d = trip;
        if (wdga_q) psc_d = tick_raw ? '0 : psc_q + PSC_W'(1);
        if (tick) t_d = t_q - CNT_W'(1);
        if (sr_wr && pwdata[1]) rstf_d = 1'b0;
        if (cr_wr) begin
            t_d    = pwdata[CNT_W-1:0];
            wdga_d = wdga_q | pwdata[31];
            psc_d  = '0;
        end
        if (cfr_wr) begin
            w_d     = pwdata[CNT_W-1:0];
            wdgtb_d = pwdata[17:16];
        end
        // Trip overrides any concurrent register write.
        if (trip) begin
            t_d     = '0;
            wdga_d  = 1'b0;
            w_d     = '1;
            wdgtb_d = 2'b00;
            psc_d   = '0;
            rstf_d  = 1'b1;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            t_q       <= '0;
            w_q       <= '1;
            psc_q     <= '0;
            wdgtb_q   <= 2'b00;
            wdga_q    <= 1'b0;
            rstf_q    <= 1'b0;
            wdt_rst_q <= 1'b0;
        end else begin
            t_q       <= t_d;
            w_q       <= w_d;
            psc_q     <= psc_d;
            wdgtb_q   <= wdgtb_d;
            wdga_q    <= wdga_d;
            rstf_q    <= rstf_d;
            wdt_rst_q <= wdt_rst_d;
        end
    end

    always_comb begin
        cr_rd         = 32'(t_q);
        cr_rd[31]     = wdga_q;
        cfr_rd        = 32'(w_q);
        cfr_rd[17:16] = wdgtb_q;
        cfr_rd[24]    = ewi_q;
        sr_rd         = {30'b0, rstf_q, ewif_q};
        prdata        = 32'b0;
        if (psel && !pwrite) begin
            if (cr_sel)       prdata = cr_rd;
            else if (cfr_sel) prdata = cfr_rd;
            else if (sr_sel)  prdata = sr_rd;
        end
    end

    assign pready   = 1'b1;
    assign pslverr  = psel & penable & ~(cr_sel | cfr_sel | sr_sel);
    assign wdt_rst  = wdt_rst_q;
    assign wdt_intr = ewif_q & ewi_q;

endmodule

// File: tb/tb_wwdt_apb.sv
// Scoreboard bench for wwdt_apb with CNT_W=7, PSC_LOG2=2 (4 cycles per tick).
module tb_wwdt_apb;
`ifdef WWDT_EWI_EN
    localparam bit EwiEn = 1'b1;
`else
    localparam bit EwiEn = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        preset;
    logic [3:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr, wdt_rst, wdt_intr;

    wwdt_apb #(.CNT_W(7), .PSC_LOG2(2)) dut (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .wdt_rst(wdt_rst), .wdt_intr(wdt_intr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } item_t;

    item_t       exp_q[$];
    logic [31:0] got_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic expect_v(input string name, input logic [31:0] v);
        item_t it;
        it.name = name;
        it.val  = v;
        exp_q.push_back(it);
    endtask

    task automatic observe(input logic [31:0] v);
        got_q.push_back(v);
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic err);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        @(posedge pclk); #1 penable = 1'b1;
        #1 d = prdata; err = pslverr;
        @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_rst(input int budget, output int cycles);
        cycles = -1;
        if (wdt_rst) cycles = 0;
        else begin
            for (int i = 1; i <= budget; i++) begin
                @(posedge pclk); #1;
                if (wdt_rst) begin
                    cycles = i;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        item_t e; logic [31:0] g, d; logic err;
        preset = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        repeat (2) @(posedge pclk);
        #1;
        expect_v("rst_wdt_rst", 0);  observe(32'(wdt_rst));
        expect_v("rst_wdt_intr", 0); observe(32'(wdt_intr));
        expect_v("rst_pready", 1);   observe(32'(pready));
        expect_v("rst_pslverr", 0);  observe(32'(pslverr));
        expect_v("rst_prdata", 0);   observe(prdata);
        preset = 1'b0;
        apb_read(4'h0, d, err); expect_v("rst_cr", 0);     observe(d);
        apb_read(4'h4, d, err); expect_v("rst_cfr", 'h7F); observe(d);
        apb_read(4'h8, d, err); expect_v("rst_sr", 0);     observe(d);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
            end
        end
    endtask

    task automatic test_normal_trip();
        item_t e; logic [31:0] g, d; logic err; int c;
        apb_write(4'h4, 32'h0000_007F);
        apb_write(4'h0, 32'h8000_0042);
        expect_v("trip_latency", 12); wait_rst(40, c); observe(32'(c));
        @(posedge pclk); #1;
        expect_v("trip_pulse_width", 0); observe(32'(wdt_rst));
        apb_read(4'h0, d, err); expect_v("trip_cr", 0);     observe(d);
        apb_read(4'h4, d, err); expect_v("trip_cfr", 'h7F); observe(d);
        apb_read(4'h8, d, err); expect_v("trip_sr", 'h2);   observe(d);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
            end
        end
    endtask

    task automatic test_early_refresh();
        item_t e; logic [31:0] g, d; logic err; int c;
        apb_write(4'h4, 32'h0000_0050);
        apb_write(4'h0, 32'h8000_007F);
        expect_v("early_no_rst_on_enable", 0); observe(32'(wdt_rst));
        apb_write(4'h0, 32'h8000_007F);
        expect_v("early_latency", 0); wait_rst(4, c); observe(32'(c));
        @(posedge pclk); #1;
        expect_v("early_pulse_width", 0); observe(32'(wdt_rst));
        apb_read(4'h0, d, err); expect_v("early_cr", 0); observe(d);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
            end
        end
    endtask

    task automatic test_legal_refresh();
        item_t e; logic [31:0] g, d; logic err, found, seen;
        apb_write(4'h4, 32'h0000_0050);
        apb_write(4'h0, 32'h8000_007F);
        found = 1'b0;
        for (int i = 0; i < 130 && !found; i++) begin
            apb_read(4'h0, d, err);
            if (d[6:0] == 7'h4F) found = 1'b1;
        end
        expect_v("legal_reached_4f", 1); observe(32'(found));
        apb_write(4'h0, 32'h8000_007F);
        seen = wdt_rst;
        apb_read(4'h0, d, err); expect_v("legal_cr", 32'h8000_007F); observe(d);
        for (int i = 0; i < 8; i++) begin
            @(posedge pclk); #1;
            seen = seen | wdt_rst;
        end
        expect_v("legal_no_rst", 0); observe(32'(seen));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
            end
        end
    endtask

    task automatic test_set_only();
        item_t e; logic [31:0] g, d; logic err;
        apb_write(4'h4, 32'h0000_007F);
        apb_write(4'h0, 32'h0000_007F);
        expect_v("setonly_no_rst", 0); observe(32'(wdt_rst));
        apb_read(4'h0, d, err); expect_v("setonly_cr", 32'h8000_007F); observe(d);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
            end
        end
    endtask

    task automatic test_early_warning();
        item_t e; logic [31:0] g, d; logic err; int c;
        apb_write(4'h8, 32'h0000_0003);
        apb_write(4'h4, 32'h0100_007F);
        apb_read(4'h4, d, err); expect_v("ewi_cfr", EwiEn ? 32'h0100_007F : 32'h7F); observe(d);
        apb_read(4'h8, d, err); expect_v("ewi_sr_cleared", 0); observe(d);
        apb_write(4'h0, 32'h8000_0041);
        repeat (4) @(posedge pclk);
        #1;
        expect_v("ewi_intr_set", 32'(EwiEn)); observe(32'(wdt_intr));
        expect_v("ewi_no_rst_yet", 0);        observe(32'(wdt_rst));
        apb_write(4'h8, 32'h0000_0001);
        expect_v("ewi_intr_cleared", 0); observe(32'(wdt_intr));
        expect_v("ewi_trip_latency", 2); wait_rst(8, c); observe(32'(c));
        apb_read(4'h8, d, err); expect_v("ewi_sr_after_trip", 'h2); observe(d);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
            end
        end
    endtask

    task automatic test_err_and_reset();
        item_t e; logic [31:0] g, d; logic err;
        apb_write(4'h4, 32'h0000_0070);
        apb_write(4'h0, 32'h8000_0060);
        repeat (6) @(posedge pclk);
        #1;
        apb_read(4'hC, d, err);
        expect_v("bad_addr_pslverr", 1); observe(32'(err));
        expect_v("bad_addr_prdata", 0);  observe(d);
        apb_write(4'hC, 32'hFFFF_FFFF);
        apb_read(4'h4, d, err); expect_v("bad_write_ignored_cfr", 'h70); observe(d);
        expect_v("good_addr_pslverr", 0); observe(32'(err));
        apb_read(4'h8, d, err); expect_v("pre_reset_sr", 'h2); observe(d);
        preset = 1'b1;
        #1 psel = 1'b1; pwrite = 1'b0; paddr = 4'h0;
        #1 expect_v("async_rst_cr", 0);      observe(prdata);
        paddr = 4'h4;
        #1 expect_v("async_rst_cfr", 'h7F);  observe(prdata);
        paddr = 4'h8;
        #1 expect_v("async_rst_sr", 0);      observe(prdata);
        psel = 1'b0;
        @(posedge pclk); #1 preset = 1'b0;
        repeat (8) @(posedge pclk);
        #1;
        apb_read(4'h0, d, err); expect_v("post_rst_cr_idle", 0); observe(d);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_trip();
        test_early_refresh();
        test_legal_refresh();
        test_set_only();
        test_early_warning();
        test_err_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
